pc_seq: RTL and testbench



---
 rtl/pc_seq.sv | 131 +++++++++++++
 tb/tb_pc_seq.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// pc_seq: fetch / decode / bit-serial execute / PC-update sequencer for the PC counter.
// Define PC_SEQ_SINGLE_STEP_EN to add i_step and a STEP_WAIT hold after each UPDATE.
module pc_seq #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
`ifdef PC_SEQ_SINGLE_STEP_EN
  input  logic              i_step,
`endif
  input  logic [ADDR_W-1:0] i_addr_pc,
  input  logic              i_branch,
  input  logic              i_br_cond,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_halt,
  input  logic              i_flag,
  output logic              o_fetch,
  output logic              o_bit_en,
  output logic [IDX_W-1:0]  o_bit_idx,
  output logic              o_con_incr,
  output logic [ADDR_W-1:0] o_addr_pcin,
  output logic              o_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
`ifdef PC_SEQ_SINGLE_STEP_EN
  localparam logic [2:0] S_STEP   = 3'd5;
`endif

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              br_q, br_d;
  logic              cond_q, cond_d;
  logic              taken;
  logic [ADDR_W-1:0] seq_pc;

  // i_flag is only consulted on the last execute bit
  assign taken  = br_q & (~cond_q | i_flag);
  assign seq_pc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    br_d    = br_q;
    cond_d  = cond_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        pc_d    = i_addr_pc;
        br_d    = i_branch;
        cond_d  = i_br_cond;
        tgt_d   = i_br_target;
        idx_d   = '0;
        state_d = i_halt ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        if (idx_q == LAST) begin
          idx_d   = '0;
          addr_d  = taken ? tgt_q : seq_pc;
          state_d = S_UPDATE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_UPDATE: begin
`ifdef PC_SEQ_SINGLE_STEP_EN
        state_d = S_STEP;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef PC_SEQ_SINGLE_STEP_EN
      S_STEP: begin
        if (i_step) state_d = S_FETCH;
      end
`endif
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      addr_q  <= '0;
      br_q    <= 1'b0;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      br_q    <= br_d;
      cond_q  <= cond_d;
    end
  end

  assign o_fetch     = (state_q == S_FETCH);
  assign o_bit_en    = (state_q == S_EXEC);
  assign o_bit_idx   = idx_q;
  assign o_con_incr  = (state_q == S_UPDATE);
  assign o_addr_pcin = addr_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: randomized self-checking bench for pc_seq against a next-PC model.
// Build with PC_SEQ_SINGLE_STEP_EN to also exercise the STEP_WAIT hold.
module tb_pc_seq;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
`ifdef PC_SEQ_SINGLE_STEP_EN
  logic              i_step;
`endif
  logic [ADDR_W-1:0] i_addr_pc;
  logic              i_branch;
  logic              i_br_cond;
  logic [ADDR_W-1:0] i_br_target;
  logic              i_halt;
  logic              i_flag;
  logic              o_fetch;
  logic              o_bit_en;
  logic [IDX_W-1:0]  o_bit_idx;
  logic              o_con_incr;
  logic [ADDR_W-1:0] o_addr_pcin;
  logic              o_busy;

  pc_seq dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
`ifdef PC_SEQ_SINGLE_STEP_EN
    .i_step      (i_step),
`endif
    .i_addr_pc   (i_addr_pc),
    .i_branch    (i_branch),
    .i_br_cond   (i_br_cond),
    .i_br_target (i_br_target),
    .i_halt      (i_halt),
    .i_flag      (i_flag),
    .o_fetch     (o_fetch),
    .o_bit_en    (o_bit_en),
    .o_bit_idx   (o_bit_idx),
    .o_con_incr  (o_con_incr),
    .o_addr_pcin (o_addr_pcin),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_incr   = 0;
  int n_overlap = 0;
  int exp_incr = 0;
  int step_hold = 0;

  always @(negedge i_clk) begin
    if (o_con_incr === 1'b1) n_incr++;
    if (o_con_incr === 1'b1 && o_fetch === 1'b1) n_overlap++;
  end

  bit                ob_fetch, ob_early, ob_bits_ok, ob_incr;
  bit                ob_upd_clean, ob_next_fetch, ob_addr_hold;
  bit                ob_busy_end, ob_idle_clean, ob_step_ok;
  logic [ADDR_W-1:0] ob_addr;

  function automatic logic [ADDR_W-1:0] model_next(
    input int pc, input bit br, input bit cond,
    input int tgt, input bit last_flag);
    if (br && (!cond || last_flag)) return ADDR_W'(tgt);
    return ADDR_W'((pc + 1) % (1 << ADDR_W));
  endfunction

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Enter at a negedge in FETCH; leave at a negedge in FETCH (or IDLE on halt).
  task automatic exec_instr(
    input logic [ADDR_W-1:0] pc, input logic br, input logic cond,
    input logic [ADDR_W-1:0] tgt, input logic halt,
    input logic [DATA_W-1:0] flags, input bit poke_start);
    ob_fetch = 0; ob_early = 0; ob_bits_ok = 0; ob_incr = 0;
    ob_upd_clean = 0; ob_next_fetch = 0; ob_addr_hold = 0;
    ob_busy_end = 1; ob_idle_clean = 0; ob_step_ok = 1; ob_addr = 'x;
    ob_fetch = (o_fetch === 1'b1) && (o_busy === 1'b1)
            && (o_bit_en === 1'b0);
    ob_early = (o_con_incr !== 1'b0);
    i_addr_pc = pc; i_branch = br; i_br_cond = cond;
    i_br_target = tgt; i_halt = halt;
    @(negedge i_clk);
    if (o_con_incr !== 1'b0 || o_fetch !== 1'b0 || o_bit_en !== 1'b0)
      ob_early = 1;
    @(negedge i_clk);
    if (!halt) exp_incr++;
    i_halt = 1'b0;
    if (halt) begin
      ob_busy_end = o_busy;
      ob_idle_clean = (o_fetch === 1'b0) && (o_bit_en === 1'b0)
                   && (o_con_incr === 1'b0) && (o_bit_idx === '0);
      return;
    end
    i_addr_pc = ADDR_W'($urandom); i_branch = 1'($urandom);
    i_br_cond = 1'($urandom); i_br_target = ADDR_W'($urandom);
    ob_bits_ok = 1;
    for (int b = 0; b < DATA_W; b++) begin
      if (o_bit_en !== 1'b1 || o_bit_idx !== IDX_W'(b)
          || o_con_incr !== 1'b0 || o_fetch !== 1'b0)
        ob_bits_ok = 0;
      i_flag = flags[b];
      i_start = (poke_start && b == 2);
      @(negedge i_clk);
    end
    i_start = 1'b0;
    i_flag = 1'($urandom);
    ob_incr = o_con_incr;
    ob_addr = o_addr_pcin;
    ob_upd_clean = (o_fetch === 1'b0) && (o_bit_en === 1'b0)
                && (o_bit_idx === '0) && (o_busy === 1'b1);
    @(negedge i_clk);
`ifdef PC_SEQ_SINGLE_STEP_EN
    for (int k = 0; k <= step_hold; k++) begin
      if (o_busy !== 1'b1 || o_fetch !== 1'b0 || o_con_incr !== 1'b0
          || o_bit_en !== 1'b0)
        ob_step_ok = 0;
      i_step = (k == step_hold);
      @(negedge i_clk);
    end
    i_step = 1'b0;
`endif
    ob_next_fetch = (o_fetch === 1'b1) && (o_con_incr === 1'b0);
    ob_addr_hold = (o_addr_pcin === ob_addr);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 0; i_addr_pc = 0; i_branch = 0;
    i_br_cond = 0; i_br_target = 0; i_halt = 0; i_flag = 0;
`ifdef PC_SEQ_SINGLE_STEP_EN
    i_step = 0;
`endif
    @(negedge i_clk);
    n_checks++;
    if ({o_fetch, o_bit_en, o_con_incr, o_busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got=%b want=0000",
               {o_fetch, o_bit_en, o_con_incr, o_busy});
    end
    n_checks++;
    if (o_bit_idx !== '0 || o_addr_pcin !== '0) begin
      n_fail++;
      $display("FAIL reset_regs idx=%0d addr=%0d want 0/0",
               o_bit_idx, o_addr_pcin);
    end
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold busy=%b want=0", o_busy);
    end
  endtask

  task automatic test_first();
    logic [DATA_W-1:0] fl;
    fl = DATA_W'($urandom);
    pulse_start();
    exec_instr(3'd0, 1'b0, 1'b0, 3'd5, 1'b0, fl, 0);
    n_checks++;
    if (!ob_fetch || ob_early) begin
      n_fail++;
      $display("FAIL first_fetch fetch=%b early=%b want 1/0",
               ob_fetch, ob_early);
    end
    n_checks++;
    if (!ob_bits_ok) begin
      n_fail++;
      $display("FAIL first_bits got=0 want=1");
    end
    n_checks++;
    if (!ob_incr || !ob_upd_clean) begin
      n_fail++;
      $display("FAIL first_update incr=%b clean=%b want 1/1",
               ob_incr, ob_upd_clean);
    end
    n_checks++;
    if (ob_addr !== model_next(0, 0, 0, 5, fl[DATA_W-1])) begin
      n_fail++;
      $display("FAIL first_addr got=%0d want=1", ob_addr);
    end
    n_checks++;
    if (!ob_next_fetch || !ob_addr_hold) begin
      n_fail++;
      $display("FAIL back_to_back fetch=%b hold=%b want 1/1",
               ob_next_fetch, ob_addr_hold);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] want;
    want = model_next(7, 0, 0, 2, 1);
    exec_instr(3'd7, 1'b0, 1'b0, 3'd2, 1'b0, 8'hFF, 0);
    n_checks++;
    if (ob_addr !== want || !ob_incr) begin
      n_fail++;
      $display("FAIL wrap got=%0d incr=%b want=%0d", ob_addr, ob_incr, want);
    end
  endtask

  task automatic test_branch();
    logic [DATA_W-1:0] fl [4];
    logic              cd [4];
    logic [ADDR_W-1:0] want;
    fl[0] = 8'h00; cd[0] = 0;
    fl[1] = 8'h7F; cd[1] = 1;
    fl[2] = 8'h08; cd[2] = 1;
    fl[3] = 8'h80; cd[3] = 1;
    for (int t = 0; t < 4; t++) begin
      want = model_next(2, 1, cd[t], 5, fl[t][DATA_W-1]);
      exec_instr(3'd2, 1'b1, cd[t], 3'd5, 1'b0, fl[t], 0);
      n_checks++;
      if (ob_addr !== want || !ob_next_fetch) begin
        n_fail++;
        $display("FAIL branch_%0d got=%0d want=%0d", t, ob_addr, want);
      end
    end
  endtask

  task automatic test_halt();
    logic [ADDR_W-1:0] prev;
    int                inc0;
    #1;
    prev = o_addr_pcin;
    inc0 = n_incr;
    exec_instr(3'd4, 1'b1, 1'b0, 3'd6, 1'b1, 8'hFF, 0);
    n_checks++;
    if (ob_busy_end !== 1'b0 || !ob_idle_clean) begin
      n_fail++;
      $display("FAIL halt_idle busy=%b clean=%b want 0/1",
               ob_busy_end, ob_idle_clean);
    end
    repeat (4) @(negedge i_clk);
    #1;
    n_checks++;
    if (o_addr_pcin !== prev || n_incr != inc0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_noload addr=%0d incr=%0d busy=%b want %0d/%0d/0",
               o_addr_pcin, n_incr - inc0, o_busy, prev, 0);
    end
  endtask

  task automatic test_start_busy();
    logic [ADDR_W-1:0] want;
    want = model_next(3, 0, 0, 0, 0);
    pulse_start();
    exec_instr(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1);
    n_checks++;
    if (!ob_bits_ok || ob_addr !== want || !ob_next_fetch) begin
      n_fail++;
      $display("FAIL start_busy bits=%b addr=%0d want 1/%0d",
               ob_bits_ok, ob_addr, want);
    end
  endtask

  task automatic test_reset_mid();
    int inc0;
    i_addr_pc = 3'd1; i_branch = 0; i_br_cond = 0; i_halt = 0;
    @(negedge i_clk);
    repeat (5) @(negedge i_clk);
    n_checks++;
    if (o_bit_idx !== IDX_W'(4) || o_bit_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pos idx=%0d en=%b want 4/1", o_bit_idx, o_bit_en);
    end
    #1;
    inc0 = n_incr;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_fetch, o_bit_en, o_con_incr, o_busy} !== 4'b0
        || o_bit_idx !== '0 || o_addr_pcin !== '0) begin
      n_fail++;
      $display("FAIL async_rst strobes=%b idx=%0d addr=%0d want 0",
               {o_fetch, o_bit_en, o_con_incr, o_busy},
               o_bit_idx, o_addr_pcin);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (12) @(negedge i_clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || n_incr != inc0) begin
      n_fail++;
      $display("FAIL rst_idle busy=%b incr=%0d want 0/0",
               o_busy, n_incr - inc0);
    end
    pulse_start();
    exec_instr(3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 0);
    n_checks++;
    if (!ob_fetch || ob_addr !== model_next(1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rst_restart fetch=%b addr=%0d want 1/2",
               ob_fetch, ob_addr);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] pc, tgt, want;
    logic              br, cd, hl;
    logic [DATA_W-1:0] fl;
    for (int n = 0; n < 40; n++) begin
      pc = ADDR_W'($urandom); tgt = ADDR_W'($urandom);
      br = 1'($urandom); cd = 1'($urandom);
      hl = ($urandom_range(0, 7) == 0);
      fl = DATA_W'($urandom);
      want = model_next(pc, br, cd, tgt, fl[DATA_W-1]);
      exec_instr(pc, br, cd, tgt, hl, fl, 0);
      n_checks++;
      if (hl) begin
        if (ob_busy_end !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_halt_%0d busy=%b want=0", n, ob_busy_end);
        end
        pulse_start();
      end else if (ob_addr !== want || !ob_incr || !ob_next_fetch
                   || !ob_bits_ok) begin
        n_fail++;
        $display("FAIL rand_%0d pc=%0d br=%b c=%b t=%0d f=%b got=%0d want=%0d",
                 n, pc, br, cd, tgt, fl[DATA_W-1], ob_addr, want);
      end
    end
  endtask

`ifdef PC_SEQ_SINGLE_STEP_EN
  task automatic test_step();
    step_hold = 20;
    exec_instr(3'd6, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 0);
    step_hold = 0;
    n_checks++;
    if (!ob_step_ok || !ob_next_fetch || ob_addr !== model_next(6, 0, 0, 0, 0))
    begin
      n_fail++;
      $display("FAIL step_wait hold=%b fetch=%b addr=%0d want 1/1/7",
               ob_step_ok, ob_next_fetch, ob_addr);
    end
  endtask
`endif

  task automatic test_invariant();
    #1;
    n_checks++;
    if (n_overlap != 0 || n_incr != exp_incr) begin
      n_fail++;
      $display("FAIL incr_count overlap=%0d incr=%0d want 0/%0d",
               n_overlap, n_incr, exp_incr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first();
    test_wrap();
    test_branch();
    test_halt();
    test_start_busy();
    test_reset_mid();
`ifdef PC_SEQ_SINGLE_STEP_EN
    test_step();
`endif
    test_random();
    test_invariant();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
